// File: rtl/program_loader.sv
// Byte-stream program loader: parses sync/count/data/checksum frames into 16-bit program
// memory writes and only releases the core once the frame checksum has been verified.
module program_loader #(
    parameter int unsigned PC_WIDTH = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                pm_we,
    output logic [PC_WIDTH-1:0] pm_addr,
    output logic [15:0]         pm_wdata,
    output logic                core_run,
    output logic                busy,
    output logic                error
);

    localparam int unsigned DEPTH = 2 ** PC_WIDTH;
    localparam logic [7:0]  SYNC  = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StHigh,
        StLow,
        StWrite,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e              state;
    logic [PC_WIDTH:0]   remaining;
    logic [7:0]          checksum;
    logic                accept;
    logic                count_ok;
    logic                is_sync;

    assign accept   = in_valid & in_ready;
    assign is_sync  = (in_data == SYNC);
    // Nine bits so that DEPTH = 256 still compares correctly against an 8-bit count.
    assign count_ok = (in_data != 8'h00) && ({1'b0, in_data} <= 9'(DEPTH));

    assign in_ready = (state != StWrite);
    assign busy     = (state != StIdle) && (state != StDone) && (state != StError);
    assign error    = (state == StError);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= StIdle;
            pm_we     <= 1'b0;
            pm_addr   <= '0;
            pm_wdata  <= '0;
            core_run  <= 1'b0;
            remaining <= '0;
            checksum  <= '0;
        end else begin
            pm_we <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept && is_sync) state <= StCount;
                end
                StCount: begin
                    if (accept) begin
                        if (count_ok) begin
                            remaining <= (PC_WIDTH + 1)'(in_data);
                            pm_addr   <= '0;
                            checksum  <= '0;
                            state     <= StHigh;
                        end else begin
                            state <= StError;
                        end
                    end
                end
                StHigh: begin
                    if (accept) begin
                        pm_wdata[15:8] <= in_data;
                        checksum       <= checksum ^ in_data;
                        state          <= StLow;
                    end
                end
                StLow: begin
                    if (accept) begin
                        pm_wdata[7:0] <= in_data;
                        checksum      <= checksum ^ in_data;
                        // Strobe is registered so it lines up exactly with the WRITE cycle.
                        pm_we         <= 1'b1;
                        state         <= StWrite;
                    end
                end
                StWrite: begin
                    pm_addr   <= pm_addr + 1'b1;
                    remaining <= remaining - 1'b1;
                    state     <= (remaining == (PC_WIDTH + 1)'(1)) ? StCheck : StHigh;
                end
                StCheck: begin
                    if (accept) begin
                        if (in_data == checksum) begin
                            core_run <= 1'b1;
                            state    <= StDone;
                        end else begin
                            state <= StError;
                        end
                    end
                end
                StDone, StError: begin
                    if (accept && is_sync) begin
                        core_run <= 1'b0;
                        state    <= StCount;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomised scoreboard bench for program_loader: expected memory writes are queued per frame
// and a monitor pops them whenever the loader strobes pm_we.
module tb_program_loader;

    localparam int unsigned PW    = 6;
    localparam int unsigned DEPTH = 2 ** PW;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          pm_we;
    logic [PW-1:0] pm_addr;
    logic [15:0]   pm_wdata;
    logic          core_run;
    logic          busy;
    logic          error;

    program_loader #(.PC_WIDTH(PW)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .pm_we    (pm_we),
        .pm_addr  (pm_addr),
        .pm_wdata (pm_wdata),
        .core_run (core_run),
        .busy     (busy),
        .error    (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit gaps     = 1'b0;

    logic [PW+15:0] exp_q[$];
    logic [15:0]    words[256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected (addr, data) pair.
    always @(negedge clock) begin
        if (pm_we === 1'b1) begin
            check("no_ready_in_write", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                         pm_addr, pm_wdata);
            end else begin
                check("write_addr_data", 32'({pm_addr, pm_wdata}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: got in_ready=0 for %0d cycles, expected 1", t);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Sends a frame and checks the outcome; words[] holds the payload.
    task automatic run_frame(input int n, input logic [7:0] cks, input bit send_sync);
        logic [7:0] x;
        bit ok;
        ok = (n >= 1) && (n <= int'(DEPTH));
        x  = 8'h00;
        if (send_sync) send_byte(8'hA5);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({PW'(i), words[i]});
                x = x ^ words[i][15:8] ^ words[i][7:0];
            end
        end
        send_byte(8'(n));
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                send_byte(words[i][15:8]);
                send_byte(words[i][7:0]);
            end
            send_byte(cks);
        end
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        check("writes_drained", 32'(exp_q.size()), 32'd0);
        check("core_run", 32'(core_run), 32'(ok && (cks == x)));
        check("error", 32'(error), 32'(!(ok && (cks == x))));
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    function automatic logic [7:0] xor_of(input int n);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < n; i++) x = x ^ words[i][15:8] ^ words[i][7:0];
        return x;
    endfunction

    task automatic check_reset_outputs();
        check("rst_pm_we", 32'(pm_we), 32'd0);
        check("rst_pm_addr", 32'(pm_addr), 32'd0);
        check("rst_pm_wdata", 32'(pm_wdata), 32'd0);
        check("rst_core_run", 32'(core_run), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_outputs();

        // Good N=2 frame, then bad checksum, then a good N=1 recovery frame.
        words[0] = 16'h1234;
        words[1] = 16'hABCD;
        run_frame(2, 8'h40, 1'b1);
        run_frame(2, 8'h41, 1'b1);
        words[0] = 16'h0007;
        run_frame(1, 8'h07, 1'b1);

        // Count errors: zero and one past full depth.
        run_frame(0, 8'h00, 1'b1);
        run_frame(DEPTH + 1, 8'h00, 1'b1);

        // Full-depth frame.
        for (int i = 0; i < int'(DEPTH); i++) words[i] = 16'(i);
        run_frame(DEPTH, xor_of(DEPTH), 1'b1);

        // Garbage in IDLE after a reset, then a frame with random handshake gaps.
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        gaps  = 1'b1;
        send_byte(8'h00);
        send_byte(8'hFF);
        check("garbage_idle_busy", 32'(busy), 32'd0);
        words[0] = 16'h1234;
        words[1] = 16'hABCD;
        run_frame(2, 8'h40, 1'b1);

        // Sync while DONE drops core_run on the accepting edge; then finish that frame.
        send_byte(8'hA5);
        check("done_sync_core_run", 32'(core_run), 32'd0);
        check("done_sync_busy", 32'(busy), 32'd1);
        words[0] = 16'hA5A5;
        run_frame(1, 8'h00, 1'b0);

        // Random frames; 0xA5 inside data is ordinary payload.
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) words[i] = 16'($urandom);
            if (f == 2) words[0] = 16'hA5A5;
            run_frame(n, ($urandom_range(0, 3) == 0) ? ~xor_of(n) : xor_of(n), 1'b1);
        end

        // Reset after the high byte of word 1 aborts without any write.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_reset_outputs();
        reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check_reset_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream loader that fills the writable program memory with 16-bit instructions and releases the CPU core only after a checksummed image has been fully written. It sits between an external byte source (UART receiver, JTAG bridge or testbench) and the program memory write port. While a load is in progress it holds the core stopped through `core_run`. It is the writer at the other end of the PC/instruction-fetch path.

## Interface
- `PC_WIDTH`, default 6: program memory address width; depth `DEPTH` = 2**PC_WIDTH words (valid range 1..8).
- `clock` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-low.
- `in_valid` input 1: source presents a byte.
- `in_data` input 8: byte value.
- `in_ready` output 1: loader accepts a byte; transfer occurs when `in_valid & in_ready` at a rising edge.
- `pm_we` output 1: program memory write strobe, one cycle per word.
- `pm_addr` output PC_WIDTH: write address.
- `pm_wdata` output 16: instruction word.
- `core_run` output 1: high when a verified image is loaded; drives the core's reset/enable.
- `busy` output 1: high in any state other than IDLE, DONE or ERROR.
- `error` output 1: high in the ERROR state.

## Operation
- Frame format: `0xA5` sync, count byte N, N words sent high byte then low byte, then checksum byte. The checksum is the XOR of all 2N data bytes; sync and count are excluded.
- Valid N is 1..DEPTH. N = 0 or N > DEPTH is a count error.
- States and transitions:
  - IDLE: `in_ready`=1. A `0xA5` byte goes to COUNT; any other byte is discarded and the state stays IDLE.
  - COUNT: `in_ready`=1. A valid N latches the remaining-word counter (= N), clears `pm_addr` to 0 and the checksum accumulator to 0, then goes to HIGH. An invalid N goes to ERROR.
  - HIGH: `in_ready`=1. The accepted byte goes to `pm_wdata[15:8]` and is XORed into the accumulator; go to LOW.
  - LOW: `in_ready`=1. The accepted byte goes to `pm_wdata[7:0]` and is XORed into the accumulator; go to WRITE.
  - WRITE: `in_ready`=0, `pm_we`=1 for exactly this cycle. On exit `pm_addr` increments and the counter decrements. If the counter was 1, go to CHECK; otherwise go to HIGH.
  - CHECK: `in_ready`=1. The accepted byte equal to the accumulator goes to DONE; any other value goes to ERROR.
  - DONE: `core_run`=1, `in_ready`=1. A `0xA5` byte goes to COUNT and drops `core_run` in the same edge. Other bytes are discarded.
  - ERROR: `error`=1, `core_run`=0, `in_ready`=1. A `0xA5` byte goes to COUNT and clears `error`. Other bytes are discarded.
- Words are written before the checksum is known. A failed checksum leaves memory partially or fully overwritten, and the core stays held.
- `pm_addr` counts only to N-1. There is no wrap, because N ≤ DEPTH is enforced in COUNT.
- A `0xA5` byte inside a frame (HIGH, LOW or CHECK) is treated as data. There is no resynchronisation mid-frame.
- `in_ready`, `busy` and `error` are decoded from the state register. `pm_we`, `pm_addr`, `pm_wdata` and `core_run` are registered or state-decoded, and must be glitch-free.

## Timing
- Reset (`reset`=0 at an edge): state becomes IDLE; `pm_we`=0, `pm_addr`=0, `pm_wdata`=0, `core_run`=0, `busy`=0, `error`=0, accumulator=0, counter=0. `in_ready` is 1 from the first cycle after reset is released.
- Reset applied mid-load aborts immediately. No further `pm_we` pulse occurs, and `core_run` stays 0 until a new frame completes.
- Word write: `pm_we` is high in the cycle after the low-byte handshake, with `pm_addr`/`pm_wdata` stable in that cycle.
- Minimum frame duration with continuous `in_valid`: 2 + 3N + 1 cycles from the sync handshake to the checksum handshake. `core_run` rises on the edge that accepts a good checksum.
- `in_valid` low stalls any accepting state indefinitely with no state change.
- The loader never asserts `in_ready` in WRITE. The source must hold `in_data` stable while `in_valid`=1 and `in_ready`=0.

## Test plan
- Load N=2 with words 0x1234, 0xABCD and checksum 0x12^0x34^0xAB^0xCD=0x40 -> `pm_we` pulses with (addr 0, 0x1234) then (addr 1, 0xABCD); `core_run`=1 after the checksum; `error`=0.
- Same frame with checksum 0x41 -> both writes occur, ERROR state, `error`=1, `core_run`=0; a following good N=1 frame (0xA5, 0x01, 0x00, 0x07, 0x07) writes 0x0007 at addr 0 and raises `core_run`.
- Count byte 0x00, then separately count 0x41 with PC_WIDTH=6 -> ERROR each time, with no `pm_we` pulse.
- Full-depth N=64 frame, words 0x0000..0x003F -> last write at `pm_addr`=63, and `core_run`=1 with a correct checksum.
- Garbage bytes 0x00, 0xFF in IDLE, then a valid frame -> the garbage is ignored and the load succeeds; with `in_valid` toggled randomly, the write order and values are unchanged.
- Assert `reset` low after the high byte of word 1 -> all outputs return to reset values with no `pm_we`; while in DONE, sending 0xA5 drops `core_run` at that edge.
